// File: rtl/id_ex_latch.sv
// ============================================================================
// id_ex_latch : decode -> execute pipeline register with immediate extension,
//               destination select, stall/flush and a saturating bubble count.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module id_ex_latch #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_IMM  = 16,
  parameter int NB_OP   = 6,
  parameter int NB_CNT  = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_Stall,
  input  logic               i_Flush,
  input  logic               i_Valid,
  input  logic               i_ALUSrc,
  input  logic [1:0]         i_ExtensionMode,
  input  logic               i_RegWrite,
  input  logic               i_MemRead,
  input  logic               i_MemWrite,
  input  logic               i_MemToReg,
  input  logic               i_RegDst,
  input  logic [NB_OP-1:0]   i_Opcode,
  input  logic [NB_OP-1:0]   i_Funct,
  input  logic [NB_DATA-1:0] i_RsData,
  input  logic [NB_DATA-1:0] i_RtData,
  input  logic [NB_IMM-1:0]  i_Immediate,
  input  logic [NB_REG-1:0]  i_Rs,
  input  logic [NB_REG-1:0]  i_Rt,
  input  logic [NB_REG-1:0]  i_Rd,
  input  logic [NB_DATA-1:0] i_PC,
  output logic               o_Valid,
  output logic               o_ALUSrc,
  output logic               o_RegWrite,
  output logic               o_MemRead,
  output logic               o_MemWrite,
  output logic               o_MemToReg,
  output logic [NB_OP-1:0]   o_Opcode,
  output logic [NB_OP-1:0]   o_Funct,
  output logic [NB_DATA-1:0] o_RsData,
  output logic [NB_DATA-1:0] o_RtData,
  output logic [NB_DATA-1:0] o_ExtImm,
  output logic [NB_REG-1:0]  o_Rs,
  output logic [NB_REG-1:0]  o_Rt,
  output logic [NB_REG-1:0]  o_WriteReg,
  output logic [NB_DATA-1:0] o_PC,
  output logic [NB_CNT-1:0]  o_BubbleCount
);

  localparam int NB_PAD = NB_DATA - NB_IMM;

  logic [NB_DATA-1:0] ext_imm;
  logic [NB_REG-1:0]  write_reg;
  logic               bubble;
  logic               cnt_full;

  always_comb begin
    ext_imm = '0;
    case (i_ExtensionMode)
      2'b00:   ext_imm = {{NB_PAD{i_Immediate[NB_IMM-1]}}, i_Immediate};
      2'b10:   ext_imm = {i_Immediate, {NB_PAD{1'b0}}};
      default: ext_imm = {{NB_PAD{1'b0}}, i_Immediate};
    endcase
  end

  assign write_reg = i_RegDst ? i_Rd : i_Rt;
  // An invalid decode slot turns into the same bubble as a flush, minus the count.
  assign bubble    = i_Flush | (~i_Stall & ~i_Valid);
  assign cnt_full  = &o_BubbleCount;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_Valid       <= 1'b0;
      o_ALUSrc      <= 1'b0;
      o_RegWrite    <= 1'b0;
      o_MemRead     <= 1'b0;
      o_MemWrite    <= 1'b0;
      o_MemToReg    <= 1'b0;
      o_Opcode      <= '0;
      o_Funct       <= '0;
      o_RsData      <= '0;
      o_RtData      <= '0;
      o_ExtImm      <= '0;
      o_Rs          <= '0;
      o_Rt          <= '0;
      o_WriteReg    <= '0;
      o_PC          <= '0;
      o_BubbleCount <= '0;
    end else if (bubble) begin
      o_Valid    <= 1'b0;
      o_ALUSrc   <= 1'b0;
      o_RegWrite <= 1'b0;
      o_MemRead  <= 1'b0;
      o_MemWrite <= 1'b0;
      o_MemToReg <= 1'b0;
      o_Opcode   <= '0;
      o_Funct    <= '0;
      o_RsData   <= '0;
      o_RtData   <= '0;
      o_ExtImm   <= '0;
      o_Rs       <= '0;
      o_Rt       <= '0;
      o_WriteReg <= '0;
      o_PC       <= '0;
      if (i_Flush && !cnt_full) begin
        o_BubbleCount <= o_BubbleCount + {{(NB_CNT-1){1'b0}}, 1'b1};
      end
    end else if (!i_Stall) begin
      o_Valid    <= 1'b1;
      o_ALUSrc   <= i_ALUSrc;
      o_RegWrite <= i_RegWrite;
      o_MemRead  <= i_MemRead;
      o_MemWrite <= i_MemWrite;
      o_MemToReg <= i_MemToReg;
      o_Opcode   <= i_Opcode;
      o_Funct    <= i_Funct;
      o_RsData   <= i_RsData;
      o_RtData   <= i_RtData;
      o_ExtImm   <= ext_imm;
      o_Rs       <= i_Rs;
      o_Rt       <= i_Rt;
      o_WriteReg <= write_reg;
      o_PC       <= i_PC;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_latch.sv
// ============================================================================
// tb_id_ex_latch : directed self-checking bench for id_ex_latch (NB_CNT = 2).
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_latch;

  logic        clk = 1'b0;
  logic        reset, stall, flush, valid, alusrc;
  logic [1:0]  extmode;
  logic        regwrite, memread, memwrite, memtoreg, regdst;
  logic [5:0]  opcode, funct;
  logic [31:0] rsdata, rtdata, pc;
  logic [15:0] imm;
  logic [4:0]  rs, rt, rd;

  logic        o_valid, o_alusrc, o_regwrite, o_memread, o_memwrite, o_memtoreg;
  logic [5:0]  o_opcode, o_funct;
  logic [31:0] o_rsdata, o_rtdata, o_extimm, o_pc;
  logic [4:0]  o_rs, o_rt, o_writereg;
  logic [1:0]  o_bubble;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_latch #(.NB_CNT(2)) dut (
    .i_clk(clk), .i_reset(reset), .i_Stall(stall), .i_Flush(flush), .i_Valid(valid),
    .i_ALUSrc(alusrc), .i_ExtensionMode(extmode), .i_RegWrite(regwrite),
    .i_MemRead(memread), .i_MemWrite(memwrite), .i_MemToReg(memtoreg), .i_RegDst(regdst),
    .i_Opcode(opcode), .i_Funct(funct), .i_RsData(rsdata), .i_RtData(rtdata),
    .i_Immediate(imm), .i_Rs(rs), .i_Rt(rt), .i_Rd(rd), .i_PC(pc),
    .o_Valid(o_valid), .o_ALUSrc(o_alusrc), .o_RegWrite(o_regwrite),
    .o_MemRead(o_memread), .o_MemWrite(o_memwrite), .o_MemToReg(o_memtoreg),
    .o_Opcode(o_opcode), .o_Funct(o_funct), .o_RsData(o_rsdata), .o_RtData(o_rtdata),
    .o_ExtImm(o_extimm), .o_Rs(o_rs), .o_Rt(o_rt), .o_WriteReg(o_writereg),
    .o_PC(o_pc), .o_BubbleCount(o_bubble)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    logic [31:0] any;
    any = {31'd0, |{o_valid, o_alusrc, o_regwrite, o_memread, o_memwrite, o_memtoreg,
                    o_opcode, o_funct, o_rsdata, o_rtdata, o_extimm, o_rs, o_rt,
                    o_writereg, o_pc, o_bubble}};
    check(tag, any, 32'd0);
  endtask

  task automatic randomize_inputs();
    valid = 1'b1; alusrc = 1'($urandom); extmode = 2'($urandom);
    regwrite = 1'b1; memread = 1'($urandom); memwrite = 1'($urandom);
    memtoreg = 1'($urandom); regdst = 1'($urandom);
    opcode = 6'($urandom); funct = 6'($urandom);
    rsdata = $urandom; rtdata = $urandom; pc = $urandom; imm = 16'($urandom);
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; valid = 1; alusrc = 0; extmode = 2'b00;
    regwrite = 0; memread = 0; memwrite = 0; memtoreg = 0; regdst = 0;
    opcode = 0; funct = 0; rsdata = 0; rtdata = 0; pc = 0; imm = 0;
    rs = 0; rt = 0; rd = 0;
  endtask

  initial begin
    // Reset with random inputs, flush asserted too to show reset priority
    reset = 1; stall = 0; flush = 1;
    randomize_inputs();
    tick();
    randomize_inputs();
    tick();
    check_zero("reset_all_zero");
    check("reset_bubble", {30'd0, o_bubble}, 32'd0);

    // ADDI: sign extension, WriteReg = Rt
    reset = 0; idle_inputs();
    alusrc = 1; extmode = 2'b00; imm = 16'hFFF0; rt = 5; rd = 7; regdst = 0;
    regwrite = 1; rs = 3; rsdata = 32'h1111_0000; pc = 32'h0000_0104; opcode = 6'h08;
    tick();
    check("addi_extimm",   o_extimm, 32'hFFFF_FFF0);
    check("addi_writereg", {27'd0, o_writereg}, 32'd5);
    check("addi_alusrc",   {31'd0, o_alusrc}, 32'd1);
    check("addi_valid",    {31'd0, o_valid}, 32'd1);
    check("addi_pc",       o_pc, 32'h0000_0104);
    check("addi_opcode",   {26'd0, o_opcode}, 32'h08);

    // ANDI zero-extend, LUI upper, mode 11 zero-extend
    extmode = 2'b01; imm = 16'h8001;
    tick();
    check("andi_extimm", o_extimm, 32'h0000_8001);
    extmode = 2'b10; imm = 16'h1234;
    tick();
    check("lui_extimm", o_extimm, 32'h1234_0000);
    extmode = 2'b11; imm = 16'h8001;
    tick();
    check("mode11_extimm", o_extimm, 32'h0000_8001);

    // R-type then a 3-cycle stall with changing inputs
    idle_inputs();
    regdst = 1; rd = 9; rt = 3; rsdata = 32'hA; rtdata = 32'hB; regwrite = 1; funct = 6'h20;
    tick();
    check("rtype_rs", o_rsdata, 32'hA);
    check("rtype_rt", o_rtdata, 32'hB);
    check("rtype_wr", {27'd0, o_writereg}, 32'd9);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rsdata = 32'h55 + i; rtdata = 32'h66 + i; rd = 5'(2 + i); valid = i[0];
      tick();
      check($sformatf("stall%0d_rs", i), o_rsdata, 32'hA);
      check($sformatf("stall%0d_rt", i), o_rtdata, 32'hB);
      check($sformatf("stall%0d_wr", i), {27'd0, o_writereg}, 32'd9);
      check($sformatf("stall%0d_valid", i), {31'd0, o_valid}, 32'd1);
    end
    stall = 0; valid = 1; rsdata = 32'h55; rtdata = 32'h66; rd = 2;
    tick();
    check("unstall_rs", o_rsdata, 32'h55);
    check("unstall_wr", {27'd0, o_writereg}, 32'd2);

    // Flush beats stall
    stall = 1; flush = 1;
    tick();
    check("flush_valid",    {31'd0, o_valid}, 32'd0);
    check("flush_regwrite", {31'd0, o_regwrite}, 32'd0);
    check("flush_rs",       o_rsdata, 32'd0);
    check("flush_bubble",   {30'd0, o_bubble}, 32'd1);

    // Stall holds the bubble count too
    flush = 0; stall = 1;
    tick();
    check("stall_bubble_hold", {30'd0, o_bubble}, 32'd1);

    // Reload, then invalid slot without flush: bubble, count unchanged
    stall = 0; valid = 1; imm = 16'h7777; extmode = 2'b01;
    tick();
    check("reload_valid", {31'd0, o_valid}, 32'd1);
    valid = 0;
    tick();
    check("invalid_valid",  {31'd0, o_valid}, 32'd0);
    check("invalid_extimm", o_extimm, 32'd0);
    check("invalid_wr",     {27'd0, o_writereg}, 32'd0);
    check("invalid_bubble", {30'd0, o_bubble}, 32'd1);

    // Saturation of the 2-bit counter from a clean reset
    reset = 1;
    tick();
    check("sat_reset", {30'd0, o_bubble}, 32'd0);
    reset = 0; flush = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat_flush%0d", i), {30'd0, o_bubble}, (i < 3) ? 32'(i + 1) : 32'd3);
    end

    // Reset mid-flush clears the counter
    reset = 1;
    tick();
    check("reset_midflush", {30'd0, o_bubble}, 32'd0);

    // Reset mid-stall clears loaded contents
    reset = 0; flush = 0; valid = 1; rsdata = 32'hDEAD; pc = 32'h40;
    tick();
    check("preload_rs", o_rsdata, 32'hDEAD);
    stall = 1; reset = 1;
    tick();
    check_zero("reset_midstall");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/id_ex_latch.md
Name: id_ex_latch

Overview:
- Pipeline register between the decode stage and the execute stage of the MIPS core.
- Captures the decode control word (ALUSrc, ExtensionMode and the memory/writeback controls) together with the operand data and register indices.
- Extends the 16-bit immediate per ExtensionMode and selects the destination register, so execute receives ready-to-use operands.
- Supports stall (hold) and flush (bubble insert), and keeps a saturating bubble counter for debug.

Parameters:
- NB_DATA, 32, data/PC width
- NB_REG, 5, register index width
- NB_IMM, 16, raw immediate width
- NB_OP, 6, opcode/funct width
- NB_CNT, 16, bubble counter width

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_Stall  in  1  hold current contents
- i_Flush  in  1  load bubble
- i_Valid  in  1  decode slot holds a real instruction
- i_ALUSrc  in  1  1 = ALU B operand is the immediate
- i_ExtensionMode  in  2  00 sign, 01 zero, 10 upper (lui), 11 zero
- i_RegWrite, i_MemRead, i_MemWrite, i_MemToReg, i_RegDst  in  1 each  decode controls
- i_Opcode, i_Funct  in  NB_OP each  instruction fields
- i_RsData, i_RtData  in  NB_DATA each  register file read data
- i_Immediate  in  NB_IMM  raw immediate
- i_Rs, i_Rt, i_Rd  in  NB_REG each  register indices
- i_PC  in  NB_DATA  PC+4 of the instruction
- o_Valid  out  1  execute slot valid
- o_ALUSrc, o_RegWrite, o_MemRead, o_MemWrite, o_MemToReg  out  1 each  registered controls
- o_Opcode, o_Funct  out  NB_OP each
- o_RsData, o_RtData, o_ExtImm  out  NB_DATA each
- o_Rs, o_Rt, o_WriteReg  out  NB_REG each
- o_PC  out  NB_DATA
- o_BubbleCount  out  NB_CNT  saturating count of inserted bubbles

Behaviour:
- All outputs are registered, with 1-cycle latency from inputs to outputs.
- Reset: every output is 0, including o_Valid and o_BubbleCount. Reset has priority over every other input.
- Per-edge priority is reset > flush > stall > load.
- Flush:
  - All controls, data fields and indices are cleared to 0 and o_Valid goes to 0.
  - o_BubbleCount increments.
  - Flush wins over a simultaneous stall.
- Stall (no flush): all outputs hold their values, including o_BubbleCount. i_Valid is ignored.
- Load with i_Valid=1: all fields capture their inputs and o_Valid goes to 1.
- Load with i_Valid=0: same result as flush (bubble), but o_BubbleCount is not incremented.
- Extension, computed combinationally from the inputs and registered into o_ExtImm:
  - 00: sign-extend bit 15.
  - 01: zero-extend.
  - 10: {imm,16'b0}.
  - 11: zero-extend.
- o_WriteReg = i_RegDst ? i_Rd : i_Rt, captured on load.
- o_BubbleCount saturates at all-ones; a further flush leaves it unchanged. It is cleared only by reset.
- Stall held over many cycles: contents stay unchanged indefinitely.
- Reset asserted mid-stall or mid-flush: state clears on that edge.
- No combinational path from any input to any output.

Test Plan:
- Reset held 2 cycles with random inputs -> all outputs 0; o_BubbleCount = 0.
- Load ADDI: i_ALUSrc=1, ExtMode=00, Imm=0xFFF0, Rt=5, RegDst=0, i_Valid=1 -> next cycle o_ExtImm=0xFFFFFFF0, o_WriteReg=5, o_ALUSrc=1, o_Valid=1.
- Load ANDI (ExtMode=01, Imm=0x8001) then lui (ExtMode=10, Imm=0x1234) -> o_ExtImm=0x00008001, then 0x12340000.
- Load R-type (RegDst=1, Rd=9, RsData=0xA, RtData=0xB), then i_Stall=1 for 3 cycles with new inputs -> outputs stay 0xA/0xB/WriteReg=9 for all 3 cycles, then update on the first unstalled edge.
- i_Stall=1 and i_Flush=1 together -> bubble: o_Valid=0, o_RegWrite=0, o_BubbleCount +1. i_Valid=0 with no flush -> bubble, count unchanged.
- With NB_CNT=2, apply 5 flushes -> o_BubbleCount = 1,2,3,3,3. Then reset -> 0.
